pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
Parametrised successor to the fixed IF/ID pipeline register. It is an elastic stage with a two-entry skid buffer, valid/ready handshakes on both sides, multi-lane (superscalar) bundles, flush, and a saturating back-pressure counter. It sits between any two pipeline stages (IF/ID first) and replaces the en/clr stall style with handshakes. Its outputs are fully registered, so timing from downstream ready is cut at up_ready.

Parameters:
DATA_W, 96, width of one lane payload (e.g. instr+PC+PC+4).
LANES, 1, lanes per bundle; legal range 1..4.
CLEAR_DATA, 1, 1 = zero stored data on rst/flush; 0 = clear only the valid bits.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill all held bundles (branch/redirect, instruction-cache flush)
up_valid  in  LANES  per-lane valid of incoming bundle
up_data  in  LANES*DATA_W  incoming bundle, lane i at [i*DATA_W +: DATA_W]
up_ready  out  1  stage can accept a bundle this cycle
dn_valid  out  LANES  per-lane valid of held output bundle
dn_data  out  LANES*DATA_W  output bundle
dn_ready  in  1  downstream accepts bundle this cycle
occupancy  out  2  bundles held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with a bundle held and dn_ready low

Behaviour:
- Storage: main register (drives dn_*) and skid register, each holding a valid mask and data.
- Bundle-valid terms: up_any = |up_valid; dn_any = |dn_valid.
- up_xfer = up_any & up_ready.
- dn_xfer = dn_any & dn_ready.
- Bundles move atomically: all lanes together, lane masks preserved. A bundle with up_valid == 0 is never stored (no bubbles held).
- up_ready = ~skid valid, driven from a register only. It does not depend combinationally on dn_ready.
- State EMPTY (occ 0):
  - up_xfer -> ONE, main <= up.
- State ONE (occ 1):
  - up_xfer only -> FULL, skid <= up.
  - dn_xfer only -> EMPTY.
  - both -> ONE, main <= up.
- State FULL (occ 2):
  - up_ready = 0.
  - dn_xfer -> ONE, main <= skid.
- Ordering is strictly FIFO.
- Latency: 1 cycle from up_xfer to dn_valid when EMPTY.
- Throughput: 1 bundle/cycle in steady state with dn_ready held high.
- flush (priority below rst):
  - Next state EMPTY, regardless of up_xfer/dn_xfer in the same cycle.
  - An incoming bundle in the flush cycle is discarded.
  - A bundle leaving downstream in the flush cycle is still a valid transfer from the consumer's view.
  - up_ready = 1 the cycle after flush.
  - stall_cnt is not affected.
- rst: everything goes to its reset value next edge; overrides flush and all transfers.
- Reset values:
  - dn_valid = 0; up_ready = 1; occupancy = 0; stall_cnt = 0.
  - dn_data = 0 when CLEAR_DATA = 1, otherwise holds its previous value.
  - Skid register: valid bits cleared, data cleared when CLEAR_DATA = 1.
- CLEAR_DATA = 1: flush also zeros main and skid data.
- dn_data is stable while dn_any & ~dn_ready. Data only changes on dn_xfer or on a fill from EMPTY.
- stall_cnt:
  - Increments when dn_any & ~dn_ready & ~flush.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst.
- occupancy always equals the state encoding.

Test Plan:
- LANES=2, rst 3 cycles, then up_valid=2'b11, data A, dn_ready=1 -> dn_valid=2'b11 with A one cycle later; occupancy=1; up_ready stays 1; streaming A,B,C,D gives 4 bundles in 4 cycles, in order.
- Fill with dn_ready=0, bundles A then B -> occupancy=2, up_ready=0 cycle 3, C held off. Raise dn_ready -> A, B, C delivered in order, none lost or duplicated. stall_cnt counts the held cycles exactly (e.g. 3).
- occupancy=2 (A,B), assert flush with up_valid=1 (C) and dn_ready=1 -> A counts as consumed. Next cycle: occupancy=0, dn_valid=0, dn_data=0 (CLEAR_DATA=1), up_ready=1, C never appears.
- up_valid=0 with up_ready=1 for 5 cycles -> occupancy stays 0, dn_valid=0. Partial mask up_valid=2'b01 -> dn_valid=2'b01 exactly.
- CNT_W=4, hold dn_any with dn_ready=0 for 20 cycles -> stall_cnt saturates at 15. flush leaves it at 15; rst clears it to 0.
- rst asserted while FULL and dn_ready=1 -> next cycle occupancy=0, dn_valid=0, up_ready=1, stall_cnt=0, no transfer of the skid bundle.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a two-entry skid buffer, multi-lane bundles,
// flush and a saturating back-pressure counter. All outputs are registered.
module pipe_skid_stage #(
    parameter int DATA_W     = 96,
    parameter int LANES      = 1,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        up_valid,
    input  logic [LANES*DATA_W-1:0] up_data,
    output logic                    up_ready,
    output logic [LANES-1:0]        dn_valid,
    output logic [LANES*DATA_W-1:0] dn_data,
    input  logic                    dn_ready,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e                  state_q, state_n;
    logic [LANES-1:0]        main_v_q, main_v_n, skid_v_q, skid_v_n;
    logic [LANES*DATA_W-1:0] main_d_q, main_d_n, skid_d_q, skid_d_n;
    logic                    rdy_q, rdy_n;
    logic [CNT_W-1:0]        stall_q, stall_n;
    logic                    up_xfer, dn_xfer;

    assign up_xfer = (|up_valid) & rdy_q;
    assign dn_xfer = (|main_v_q) & dn_ready;

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state_q;
        main_v_n = main_v_q;
        main_d_n = main_d_q;
        skid_v_n = skid_v_q;
        skid_d_n = skid_d_q;
        unique case (state_q)
            S_EMPTY: begin
                if (up_xfer) begin
                    state_n  = S_ONE;
                    main_v_n = up_valid;
                    main_d_n = up_data;
                end
            end
            S_ONE: begin
                if (up_xfer && dn_xfer) begin
                    main_v_n = up_valid;
                    main_d_n = up_data;
                end else if (up_xfer) begin
                    state_n  = S_FULL;
                    skid_v_n = up_valid;
                    skid_d_n = up_data;
                end else if (dn_xfer) begin
                    state_n  = S_EMPTY;
                    main_v_n = '0;
                end
            end
            S_FULL: begin
                if (dn_xfer) begin
                    state_n  = S_ONE;
                    main_v_n = skid_v_q;
                    main_d_n = skid_d_q;
                    skid_v_n = '0;
                end
            end
            default: state_n = S_EMPTY;
        endcase

        // Flush kills everything held, including a bundle arriving this cycle.
        if (flush) begin
            state_n  = S_EMPTY;
            main_v_n = '0;
            skid_v_n = '0;
            if (CLEAR_DATA) begin
                main_d_n = '0;
                skid_d_n = '0;
            end
        end
    end

    always_comb begin
        rdy_n   = (state_n != S_FULL);
        stall_n = stall_q;
        if ((|main_v_q) && !dn_ready && !flush && !(&stall_q))
            stall_n = stall_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            main_v_q <= '0;
            skid_v_q <= '0;
            rdy_q    <= 1'b1;
            stall_q  <= '0;
            // NOTE: payload storage is only cleared when CLEAR_DATA asks for it;
            // otherwise the valid bits alone mark it empty and data keeps its value.
            if (CLEAR_DATA) begin
                main_d_q <= '0;
                skid_d_q <= '0;
            end
        end else begin
            state_q  <= state_n;
            main_v_q <= main_v_n;
            main_d_q <= main_d_n;
            skid_v_q <= skid_v_n;
            skid_d_q <= skid_d_n;
            rdy_q    <= rdy_n;
            stall_q  <= stall_n;
        end
    end

    assign up_ready  = rdy_q;
    assign dn_valid  = main_v_q;
    assign dn_data   = main_d_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule
